pcie_write_desc_sched: RTL and testbench
========================================

Name: pcie_write_desc_sched

Overview:
- Scheduler sharing the single PCIe DMA write descriptor channel between PORT_COUNT requesters, e.g. the core TX path and a host-status writer.
- Grants requesters round-robin, allocates one PCIe DMA tag slot per descriptor, and caps in-flight descriptors per requester.
- On DMA completion, the block maps the status back to the originating requester and its original tag.
- Sits between the requester descriptor sources and the PCIe DMA write engine in the pcie_clk domain.

Parameters:
- PORT_COUNT, 2, number of requesters.
- PORT_WIDTH, $clog2(PORT_COUNT) (min 1), requester index width.
- PCIE_ADDR_WIDTH, 64, host address width.
- RAM_ADDR_WIDTH, 15, DMA RAM address width.
- PCIE_DMA_LEN_WIDTH, 16, length width.
- REQ_TAG_WIDTH, 8, per-requester tag width.
- PCIE_SLOT_COUNT, 16, DMA tag slots (power of 2).
- PCIE_SLOT_WIDTH, $clog2(PCIE_SLOT_COUNT), DMA tag width.
- MAX_OUTSTANDING, 8, per-port in-flight cap (1..PCIE_SLOT_COUNT).
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width.

Ports:
- pcie_clk  in  1  clock.
- pcie_rst_n  in  1  asynchronous active-low reset.
- dma_enable  in  1  permits new grants.
- s_desc_pcie_addr  in  PORT_COUNT*PCIE_ADDR_WIDTH  per-port host address.
- s_desc_ram_addr  in  PORT_COUNT*RAM_ADDR_WIDTH  per-port RAM address.
- s_desc_len  in  PORT_COUNT*PCIE_DMA_LEN_WIDTH  per-port length.
- s_desc_tag  in  PORT_COUNT*REQ_TAG_WIDTH  per-port tag.
- s_desc_valid  in  PORT_COUNT  per-port valid.
- s_desc_ready  out  PORT_COUNT  per-port ready (grant).
- s_status_tag  out  PORT_COUNT*REQ_TAG_WIDTH  returned original tag.
- s_status_valid  out  PORT_COUNT  1-cycle status pulse.
- m_desc_pcie_addr  out  PCIE_ADDR_WIDTH  to DMA engine.
- m_desc_ram_addr  out  RAM_ADDR_WIDTH  to DMA engine.
- m_desc_len  out  PCIE_DMA_LEN_WIDTH  to DMA engine.
- m_desc_tag  out  PCIE_SLOT_WIDTH  allocated slot.
- m_desc_valid  out  1  descriptor valid.
- m_desc_ready  in  1  DMA engine accepts.
- m_status_tag  in  PCIE_SLOT_WIDTH  completed slot.
- m_status_valid  in  1  completion pulse.
- status_err  out  1  pulse: status for an unallocated slot.

Behaviour:
- Reset (pcie_rst_n low, async): all outputs 0, all slots free, outstanding counters 0, RR pointer 0. Reset mid-operation discards all state; later statuses for pre-reset slots are spurious.
- Eligible port p: s_desc_valid[p] && outstanding[p] < MAX_OUTSTANDING.
- Grant condition: dma_enable && any free slot && any eligible port && (!m_desc_valid || m_desc_ready).
- Granted port: the first eligible port at or after the RR pointer, wrapping. After the grant, the pointer becomes granted+1 mod PORT_COUNT.
- s_desc_ready is a combinational one-hot of the grant; at most one bit high per cycle.
- Slot choice: lowest-index free slot.
- On grant: record {port, tag} in the slot table, mark the slot busy, increment outstanding[port].
- m_desc_* is registered in the grant cycle; m_desc_valid rises the next cycle (1-cycle latency) and holds with stable data until m_desc_ready.
- Back-to-back grants are allowed when m_desc_ready is high, giving 1 descriptor per cycle.
- On m_status_valid with slot s busy:
  - Next cycle: s_status_tag[port] = stored tag, s_status_valid[port] = 1 for 1 cycle.
  - Slot s is freed and outstanding[port] decremented.
- A slot freed in cycle N is allocatable from cycle N+1, never in the same cycle.
- m_status_valid for a free slot: no state change; status_err pulses 1 cycle later.
- Grant and completion for the same port in the same cycle: outstanding unchanged.
- All slots busy: no grants, ready low. A port at its cap is skipped without stalling other ports.
- dma_enable low: no new grants; a pending m_desc is still presented; completions are still processed.
- Only one completion arrives per cycle, so s_status_valid is at most one-hot.

Optional Feature:
- Macro: PCIE_WRITE_DESC_SCHED_STATS_EN.
- With the macro defined, the block adds:
  - input stats_clear (1).
  - output stats_grant_cnt (PORT_COUNT*32): per-port 32-bit wrapping counts of granted descriptors.
  - output stats_stall_cnt (32): cycles in which some port was valid but no grant occurred.
- stats_clear zeroes both counters synchronously; clear takes priority over increment in the same cycle. Both counters reset to 0.
- Without the macro: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Single port 0, tag 0x5A, addr 0x1000_0000, len 2048, m_desc_ready=1:
  - m_desc_valid high 1 cycle after the grant, m_desc_tag=0.
  - m_status_tag=0 pulse -> next cycle s_status_valid=2'b01, s_status_tag[0]=0x5A.
- Both ports continuously valid, m_desc_ready=1 -> grants alternate 0,1,0,1; slots 0,1,2,3; then stall at MAX_OUTSTANDING=8 each with all 16 slots busy.
- Port 0 only, no completions -> exactly 8 grants, then s_desc_ready[0]=0. One completion -> exactly 1 more grant, issued 1 cycle after the free.
- m_desc_ready held low 5 cycles with m_desc_valid=1 -> output data stable; no further grants; both ready bits low.
- m_status_tag=3 while slot 3 is free -> status_err pulse, no s_status_valid, counters unchanged. Simultaneous grant+completion on port 1 -> outstanding[1] unchanged.
- Assert pcie_rst_n low mid-burst with 4 slots busy -> outputs 0 immediately. After release: a status for slot 2 gives status_err; the next grant uses slot 0.

Source files
------------

// File: rtl/pcie_write_desc_sched.sv
`default_nettype none
// ============================================================================
// Module      : pcie_write_desc_sched
// Description : Shares one PCIe DMA write descriptor channel between
//               PORT_COUNT requesters. Round-robin grant, lowest-free DMA
//               tag slot allocation, per-requester in-flight cap, and
//               routing of DMA completions back to the originating
//               requester with its original tag.
// Ports       : pcie_clk / pcie_rst_n   - clock, async active-low reset
//               dma_enable              - permits new grants
//               s_desc_*                - per-requester descriptor inputs,
//                                         s_desc_ready is the one-hot grant
//               s_status_*              - per-requester completion pulse
//               m_desc_*                - registered descriptor to DMA engine
//               m_status_*              - DMA completion (slot index)
//               status_err              - completion for an unallocated slot
// Option      : `define PCIE_WRITE_DESC_SCHED_STATS_EN adds stats_clear,
//               stats_grant_cnt (per-port grants) and stats_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_write_desc_sched #(
  parameter int PORT_COUNT         = 2,
  parameter int PORT_WIDTH         = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
  parameter int PCIE_ADDR_WIDTH    = 64,
  parameter int RAM_ADDR_WIDTH     = 15,
  parameter int PCIE_DMA_LEN_WIDTH = 16,
  parameter int REQ_TAG_WIDTH      = 8,
  parameter int PCIE_SLOT_COUNT    = 16,
  parameter int PCIE_SLOT_WIDTH    = $clog2(PCIE_SLOT_COUNT),
  parameter int MAX_OUTSTANDING    = 8,
  parameter int CNT_WIDTH          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                     pcie_clk,
  input  logic                                     pcie_rst_n,
  input  logic                                     dma_enable,
`ifdef PCIE_WRITE_DESC_SCHED_STATS_EN
  input  logic                                     stats_clear,
  output logic [PORT_COUNT*32-1:0]                 stats_grant_cnt,
  output logic [31:0]                              stats_stall_cnt,
`endif
  input  logic [PORT_COUNT*PCIE_ADDR_WIDTH-1:0]    s_desc_pcie_addr,
  input  logic [PORT_COUNT*RAM_ADDR_WIDTH-1:0]     s_desc_ram_addr,
  input  logic [PORT_COUNT*PCIE_DMA_LEN_WIDTH-1:0] s_desc_len,
  input  logic [PORT_COUNT*REQ_TAG_WIDTH-1:0]      s_desc_tag,
  input  logic [PORT_COUNT-1:0]                    s_desc_valid,
  output logic [PORT_COUNT-1:0]                    s_desc_ready,
  output logic [PORT_COUNT*REQ_TAG_WIDTH-1:0]      s_status_tag,
  output logic [PORT_COUNT-1:0]                    s_status_valid,
  output logic [PCIE_ADDR_WIDTH-1:0]               m_desc_pcie_addr,
  output logic [RAM_ADDR_WIDTH-1:0]                m_desc_ram_addr,
  output logic [PCIE_DMA_LEN_WIDTH-1:0]            m_desc_len,
  output logic [PCIE_SLOT_WIDTH-1:0]               m_desc_tag,
  output logic                                     m_desc_valid,
  input  logic                                     m_desc_ready,
  input  logic [PCIE_SLOT_WIDTH-1:0]               m_status_tag,
  input  logic                                     m_status_valid,
  output logic                                     status_err
);

  // (base + off) mod PORT_COUNT, for off < PORT_COUNT
  function automatic logic [PORT_WIDTH-1:0] f_wrap(input int base, input int off);
    int v;
    v = base + off;
    if (v >= PORT_COUNT) v = v - PORT_COUNT;
    return PORT_WIDTH'(v);
  endfunction

  logic [PCIE_SLOT_COUNT-1:0]          r_slot_busy;
  logic [PORT_WIDTH-1:0]               r_slot_port [PCIE_SLOT_COUNT];
  logic [REQ_TAG_WIDTH-1:0]            r_slot_tag  [PCIE_SLOT_COUNT];
  logic [PORT_WIDTH-1:0]               r_rr_ptr;

  logic [PCIE_ADDR_WIDTH-1:0]          r_m_desc_pcie_addr;
  logic [RAM_ADDR_WIDTH-1:0]           r_m_desc_ram_addr;
  logic [PCIE_DMA_LEN_WIDTH-1:0]       r_m_desc_len;
  logic [PCIE_SLOT_WIDTH-1:0]          r_m_desc_tag;
  logic                                r_m_desc_valid;
  logic [PORT_COUNT*REQ_TAG_WIDTH-1:0] r_s_status_tag;
  logic [PORT_COUNT-1:0]               r_s_status_valid;
  logic                                r_status_err;

  logic [PORT_COUNT-1:0]               w_eligible;
  logic                                w_free_found;
  logic [PCIE_SLOT_WIDTH-1:0]          w_free_slot;
  logic                                w_sel_found;
  logic [PORT_WIDTH-1:0]               w_sel_port;
  logic                                w_grant;
  logic                                w_cpl_hit;
  logic [PORT_WIDTH-1:0]               w_cpl_port;

  // Lowest-index free slot: scan downwards so the lowest match is written last.
  always_comb begin
    w_free_found = 1'b0;
    w_free_slot  = '0;
    for (int s = PCIE_SLOT_COUNT - 1; s >= 0; s--) begin
      if (!r_slot_busy[s]) begin
        w_free_found = 1'b1;
        w_free_slot  = PCIE_SLOT_WIDTH'(s);
      end
    end
  end

  // First eligible port at or after the RR pointer; scanning offsets
  // downwards leaves the smallest offset as the winner.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_port  = '0;
    for (int i = PORT_COUNT - 1; i >= 0; i--) begin
      if (w_eligible[f_wrap(int'(r_rr_ptr), i)]) begin
        w_sel_found = 1'b1;
        w_sel_port  = f_wrap(int'(r_rr_ptr), i);
      end
    end
  end

  // Reset term keeps the combinational grant quiet while held in reset.
  assign w_grant    = pcie_rst_n && dma_enable && w_free_found && w_sel_found &&
                      (!r_m_desc_valid || m_desc_ready);
  assign w_cpl_hit  = m_status_valid && r_slot_busy[m_status_tag];
  assign w_cpl_port = r_slot_port[m_status_tag];

  // Per-port eligibility, grant decode and in-flight counter.
  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
    logic [CNT_WIDTH-1:0] r_outstanding;
    logic                 w_inc;
    logic                 w_dec;

    assign w_eligible[p]   = s_desc_valid[p] && (r_outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
    assign s_desc_ready[p] = w_grant && (w_sel_port == PORT_WIDTH'(p));
    assign w_inc           = s_desc_ready[p];
    assign w_dec           = w_cpl_hit && (w_cpl_port == PORT_WIDTH'(p));

    // Simultaneous grant and completion cancel out.
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
        r_outstanding <= '0;
      end else if (w_inc && !w_dec) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
    end
  end

  // Slot table payload; validity lives in r_slot_busy so no reset needed.
  always_ff @(posedge pcie_clk) begin
    if (w_grant) begin
      r_slot_port[w_free_slot] <= w_sel_port;
      r_slot_tag[w_free_slot]  <= s_desc_tag[int'(w_sel_port)*REQ_TAG_WIDTH +: REQ_TAG_WIDTH];
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      r_slot_busy        <= '0;
      r_rr_ptr           <= '0;
      r_m_desc_pcie_addr <= '0;
      r_m_desc_ram_addr  <= '0;
      r_m_desc_len       <= '0;
      r_m_desc_tag       <= '0;
      r_m_desc_valid     <= 1'b0;
      r_s_status_tag     <= '0;
      r_s_status_valid   <= '0;
      r_status_err       <= 1'b0;
    end else begin
      r_s_status_valid <= '0;
      r_status_err     <= m_status_valid && !r_slot_busy[m_status_tag];

      // The completing slot is busy and the granted slot is free, so the
      // two updates below never touch the same slot.
      if (w_cpl_hit) begin
        r_slot_busy[m_status_tag]    <= 1'b0;
        r_s_status_valid[w_cpl_port] <= 1'b1;
        r_s_status_tag[int'(w_cpl_port)*REQ_TAG_WIDTH +: REQ_TAG_WIDTH] <= r_slot_tag[m_status_tag];
      end

      if (w_grant) begin
        r_slot_busy[w_free_slot] <= 1'b1;
        r_rr_ptr                 <= f_wrap(int'(w_sel_port), 1);
        r_m_desc_pcie_addr <= s_desc_pcie_addr[int'(w_sel_port)*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
        r_m_desc_ram_addr  <= s_desc_ram_addr[int'(w_sel_port)*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        r_m_desc_len       <= s_desc_len[int'(w_sel_port)*PCIE_DMA_LEN_WIDTH +: PCIE_DMA_LEN_WIDTH];
        r_m_desc_tag       <= w_free_slot;
        r_m_desc_valid     <= 1'b1;
      end else if (m_desc_ready) begin
        r_m_desc_valid <= 1'b0;
      end
    end
  end

  assign m_desc_pcie_addr = r_m_desc_pcie_addr;
  assign m_desc_ram_addr  = r_m_desc_ram_addr;
  assign m_desc_len       = r_m_desc_len;
  assign m_desc_tag       = r_m_desc_tag;
  assign m_desc_valid     = r_m_desc_valid;
  assign s_status_tag     = r_s_status_tag;
  assign s_status_valid   = r_s_status_valid;
  assign status_err       = r_status_err;

`ifdef PCIE_WRITE_DESC_SCHED_STATS_EN
  logic [31:0] r_stall_cnt;

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_stats
    logic [31:0] r_grant_cnt;
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
        r_grant_cnt <= '0;
      end else if (stats_clear) begin
        r_grant_cnt <= '0;
      end else if (s_desc_ready[p]) begin
        r_grant_cnt <= r_grant_cnt + 32'd1;
      end
    end
    assign stats_grant_cnt[p*32 +: 32] = r_grant_cnt;
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      r_stall_cnt <= '0;
    end else if (stats_clear) begin
      r_stall_cnt <= '0;
    end else if ((|s_desc_valid) && !w_grant) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
  assign stats_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcie_write_desc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_write_desc_sched
// Description : Scoreboard bench for pcie_write_desc_sched. Stimulus pushes
//               expected descriptors / statuses / errors into queues; a
//               negedge monitor pops and compares on every DUT output event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_write_desc_sched;
  localparam logic [63:0] A0 = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A1 = 64'h0000_0000_2000_0040;
  localparam logic [14:0] R0 = 15'h0100;
  localparam logic [14:0] R1 = 15'h0200;
  localparam logic [15:0] L0 = 16'd2048;
  localparam logic [15:0] L1 = 16'd512;
  localparam logic [7:0]  T0 = 8'h5A;
  localparam logic [7:0]  T1 = 8'hA5;

  logic          pcie_clk = 1'b0;
  logic          pcie_rst_n = 1'b1;
  logic          dma_enable = 1'b1;
  logic [127:0]  s_desc_pcie_addr;
  logic [29:0]   s_desc_ram_addr;
  logic [31:0]   s_desc_len;
  logic [15:0]   s_desc_tag;
  logic [1:0]    s_desc_valid = 2'b00;
  logic [1:0]    s_desc_ready;
  logic [15:0]   s_status_tag;
  logic [1:0]    s_status_valid;
  logic [63:0]   m_desc_pcie_addr;
  logic [14:0]   m_desc_ram_addr;
  logic [15:0]   m_desc_len;
  logic [3:0]    m_desc_tag;
  logic          m_desc_valid;
  logic          m_desc_ready = 1'b1;
  logic [3:0]    m_status_tag = 4'd0;
  logic          m_status_valid = 1'b0;
  logic          status_err;
`ifdef PCIE_WRITE_DESC_SCHED_STATS_EN
  logic          stats_clear = 1'b0;
  logic [63:0]   stats_grant_cnt;
  logic [31:0]   stats_stall_cnt;
`endif

  assign s_desc_pcie_addr = {A1, A0};
  assign s_desc_ram_addr  = {R1, R0};
  assign s_desc_len       = {L1, L0};
  assign s_desc_tag       = {T1, T0};

  always #5 pcie_clk = ~pcie_clk;

  pcie_write_desc_sched dut (
    .pcie_clk         (pcie_clk),
    .pcie_rst_n       (pcie_rst_n),
    .dma_enable       (dma_enable),
`ifdef PCIE_WRITE_DESC_SCHED_STATS_EN
    .stats_clear      (stats_clear),
    .stats_grant_cnt  (stats_grant_cnt),
    .stats_stall_cnt  (stats_stall_cnt),
`endif
    .s_desc_pcie_addr (s_desc_pcie_addr),
    .s_desc_ram_addr  (s_desc_ram_addr),
    .s_desc_len       (s_desc_len),
    .s_desc_tag       (s_desc_tag),
    .s_desc_valid     (s_desc_valid),
    .s_desc_ready     (s_desc_ready),
    .s_status_tag     (s_status_tag),
    .s_status_valid   (s_status_valid),
    .m_desc_pcie_addr (m_desc_pcie_addr),
    .m_desc_ram_addr  (m_desc_ram_addr),
    .m_desc_len       (m_desc_len),
    .m_desc_tag       (m_desc_tag),
    .m_desc_valid     (m_desc_valid),
    .m_desc_ready     (m_desc_ready),
    .m_status_tag     (m_status_tag),
    .m_status_valid   (m_status_valid),
    .status_err       (status_err)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [14:0] ram;
    logic [15:0] len;
    logic [3:0]  slot;
  } desc_t;

  typedef struct packed {
    logic       port;
    logic [7:0] tag;
  } stat_t;

  desc_t exp_desc_q[$];
  stat_t exp_stat_q[$];
  bit    exp_err_q[$];
  desc_t mon_d;
  stat_t mon_s;
  bit    mon_e;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic desc_t mk_desc(input int port, input int slot);
    desc_t d;
    d.addr = (port == 1) ? A1 : A0;
    d.ram  = (port == 1) ? R1 : R0;
    d.len  = (port == 1) ? L1 : L0;
    d.slot = 4'(slot);
    return d;
  endfunction

  function automatic stat_t mk_stat(input int port);
    stat_t s;
    s.port = (port == 1);
    s.tag  = (port == 1) ? T1 : T0;
    return s;
  endfunction

  // Monitor: every handshake / status pulse / error pulse must match the head
  // of its expectation queue.
  always @(negedge pcie_clk) begin
    if (pcie_rst_n) begin
      if (m_desc_valid && m_desc_ready) begin
        if (exp_desc_q.size() == 0) begin
          check("desc_unexpected", 128'(m_desc_tag), 128'hFFFF);
        end else begin
          mon_d = exp_desc_q.pop_front();
          check("desc", 128'({m_desc_pcie_addr, m_desc_ram_addr, m_desc_len, m_desc_tag}), 128'(mon_d));
        end
      end
      if (|s_status_valid) begin
        if (exp_stat_q.size() == 0) begin
          check("status_unexpected", 128'(s_status_valid), 128'h0);
        end else begin
          mon_s = exp_stat_q.pop_front();
          check("status_valid", 128'(s_status_valid), 128'(2'b01 << mon_s.port));
          check("status_tag", 128'(s_status_tag[mon_s.port*8 +: 8]), 128'(mon_s.tag));
        end
      end
      if (status_err) begin
        if (exp_err_q.size() == 0) begin
          check("err_unexpected", 128'(status_err), 128'h0);
        end else begin
          mon_e = exp_err_q.pop_front();
          check("status_err", 128'(status_err), 128'(mon_e));
        end
      end
    end
  end

  task automatic step();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic do_reset();
    pcie_rst_n = 1'b0;
    #1;
    check("rst_m_desc_valid", 128'(m_desc_valid), 128'h0);
    check("rst_s_desc_ready", 128'(s_desc_ready), 128'h0);
    check("rst_s_status_valid", 128'(s_status_valid), 128'h0);
    check("rst_status_err", 128'(status_err), 128'h0);
    exp_desc_q.delete();
    exp_stat_q.delete();
    exp_err_q.delete();
    step();
    step();
    pcie_rst_n = 1'b1;
  endtask

  task automatic status_pulse(input int slot);
    m_status_tag   = 4'(slot);
    m_status_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();

    // Single descriptor from port 0, then its completion.
    s_desc_valid = 2'b01;
    @(negedge pcie_clk);
    check("t1_ready", 128'(s_desc_ready), 128'h1);
    check("t1_mvalid_grant_cycle", 128'(m_desc_valid), 128'h0);
    exp_desc_q.push_back(mk_desc(0, 0));
    step();
    s_desc_valid = 2'b00;
    @(negedge pcie_clk);
    check("t1_mvalid_next", 128'(m_desc_valid), 128'h1);
    step();
    status_pulse(0);
    exp_stat_q.push_back(mk_stat(0));
    @(negedge pcie_clk);
    check("t1_status_not_yet", 128'(s_status_valid), 128'h0);
    step();
    m_status_valid = 1'b0;
    @(negedge pcie_clk);
    check("t1_mvalid_drained", 128'(m_desc_valid), 128'h0);
    step();

    // Both ports saturate: alternate grants, slots 0..15, then stall.
    do_reset();
    s_desc_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      @(negedge pcie_clk);
      check("t2_ready_alt", 128'(s_desc_ready), (k % 2) ? 128'h2 : 128'h1);
      exp_desc_q.push_back(mk_desc(k % 2, k));
      step();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge pcie_clk);
      check("t2_ready_full", 128'(s_desc_ready), 128'h0);
      step();
    end
    status_pulse(5);
    exp_stat_q.push_back(mk_stat(1));
    @(negedge pcie_clk);
    check("t2_no_same_cycle_reuse", 128'(s_desc_ready), 128'h0);
    step();
    m_status_valid = 1'b0;
    @(negedge pcie_clk);
    check("t2_regrant_slot5", 128'(s_desc_ready), 128'h2);
    exp_desc_q.push_back(mk_desc(1, 5));
    step();
    status_pulse(7);
    exp_stat_q.push_back(mk_stat(1));
    @(negedge pcie_clk);
    check("t2_full_again", 128'(s_desc_ready), 128'h0);
    step();
    status_pulse(9);
    exp_stat_q.push_back(mk_stat(1));
    @(negedge pcie_clk);
    check("t2_grant_with_cpl", 128'(s_desc_ready), 128'h2);
    exp_desc_q.push_back(mk_desc(1, 7));
    step();
    m_status_valid = 1'b0;
    @(negedge pcie_clk);
    check("t2_count_unchanged", 128'(s_desc_ready), 128'h2);
    exp_desc_q.push_back(mk_desc(1, 9));
    step();
    @(negedge pcie_clk);
    check("t2_final_full", 128'(s_desc_ready), 128'h0);
    step();
    s_desc_valid = 2'b00;
    step();

    // Port 0 alone hits its cap; one completion lets exactly one more through.
    do_reset();
    s_desc_valid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(negedge pcie_clk);
      check("t3_ready", 128'(s_desc_ready), 128'h1);
      exp_desc_q.push_back(mk_desc(0, k));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge pcie_clk);
      check("t3_cap", 128'(s_desc_ready), 128'h0);
      step();
    end
    status_pulse(3);
    exp_stat_q.push_back(mk_stat(0));
    @(negedge pcie_clk);
    check("t3_cap_during_cpl", 128'(s_desc_ready), 128'h0);
    step();
    m_status_valid = 1'b0;
    @(negedge pcie_clk);
    check("t3_one_more", 128'(s_desc_ready), 128'h1);
    exp_desc_q.push_back(mk_desc(0, 3));
    step();
    @(negedge pcie_clk);
    check("t3_cap_again", 128'(s_desc_ready), 128'h0);

    // Backpressure from the DMA engine holds the descriptor stable.
    step();
    m_desc_ready = 1'b0;
    s_desc_valid = 2'b11;
    @(negedge pcie_clk);
    check("t4_grant_p1", 128'(s_desc_ready), 128'h2);
    exp_desc_q.push_back(mk_desc(1, 8));
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge pcie_clk);
      check("t4_ready_low", 128'(s_desc_ready), 128'h0);
      check("t4_mvalid_hold", 128'(m_desc_valid), 128'h1);
      check("t4_data_hold", 128'({m_desc_pcie_addr, m_desc_ram_addr, m_desc_len, m_desc_tag}),
            128'(mk_desc(1, 8)));
      step();
    end
    m_desc_ready = 1'b1;
    s_desc_valid = 2'b00;
    step();

    // Disabled: no grants, completions still processed.
    dma_enable   = 1'b0;
    s_desc_valid = 2'b10;
    status_pulse(8);
    exp_stat_q.push_back(mk_stat(1));
    @(negedge pcie_clk);
    check("t4_disabled", 128'(s_desc_ready), 128'h0);
    step();
    m_status_valid = 1'b0;
    @(negedge pcie_clk);
    check("t4_disabled_after_free", 128'(s_desc_ready), 128'h0);
    step();
    s_desc_valid = 2'b00;
    dma_enable   = 1'b1;
    step();

    // Status for a free slot: error pulse only, slot state untouched.
    do_reset();
    status_pulse(3);
    exp_err_q.push_back(1'b1);
    step();
    m_status_valid = 1'b0;
    @(negedge pcie_clk);
    check("t5_err_pulse", 128'(status_err), 128'h1);
    check("t5_no_status", 128'(s_status_valid), 128'h0);
    step();
    s_desc_valid = 2'b01;
    @(negedge pcie_clk);
    check("t5_grant", 128'(s_desc_ready), 128'h1);
    exp_desc_q.push_back(mk_desc(0, 0));
    step();
    s_desc_valid = 2'b00;
    step();

    // Reset mid-burst with four slots busy.
    do_reset();
    s_desc_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge pcie_clk);
      check("t6_ready", 128'(s_desc_ready), (k % 2) ? 128'h2 : 128'h1);
      exp_desc_q.push_back(mk_desc(k % 2, k));
      step();
    end
    check("t6_mvalid_before_rst", 128'(m_desc_valid), 128'h1);
    do_reset();
    s_desc_valid = 2'b00;
    status_pulse(2);
    exp_err_q.push_back(1'b1);
    step();
    m_status_valid = 1'b0;
    s_desc_valid   = 2'b01;
    @(negedge pcie_clk);
    check("t6_post_rst_grant", 128'(s_desc_ready), 128'h1);
    exp_desc_q.push_back(mk_desc(0, 0));
    step();
    s_desc_valid = 2'b00;
    repeat (3) step();

    check("end_desc_q_empty", 128'(exp_desc_q.size()), 128'h0);
    check("end_stat_q_empty", 128'(exp_stat_q.size()), 128'h0);
    check("end_err_q_empty", 128'(exp_err_q.size()), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
